// File: rtl/mmio_periph.sv
// mmio_periph
// Memory-mapped I/O responder on the CPU data-memory port. It decodes the
// 16-byte window at 0x4000_0000 and holds four registers there:
//   0x0 LED  (RW)  [7:0] drives oLED
//   0x4 SW   (RO)  [7:0] debounced switches, [8] change flag (cleared by read)
//   0x8 DIGI (RW)  [15:0] four hex nibbles, nibble n shown on digit n
//   0xC CTRL (RW)  [0] display enable, [1] decimal point on digit 0
// Ports:
//   iClk, iRst_n       clock, synchronous active-low reset
//   iAddr/iWData       byte address and store data
//   iWE/iRE            single-cycle write/read strobes
//   oRData/oReady      read data and one-cycle completion pulse (next cycle)
//   iSwitch            raw asynchronous switches
//   oLED               LED drive, active-high
//   oDigi              [11:8] anodes active-low, [7:0] segments {dp,g..a} active-low
module mmio_periph #(
    parameter int unsigned SCAN_DIV   = 1024,
    parameter int unsigned DEB_CYCLES = 4096
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWData,
    input  logic        iWE,
    input  logic        iRE,
    output logic [31:0] oRData,
    output logic        oReady,
    input  logic [7:0]  iSwitch,
    output logic [7:0]  oLED,
    output logic [11:0] oDigi
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_SAT   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD  = DEB_W'(DEB_CYCLES - 2);

    typedef enum logic [1:0] {
        REG_LED  = 2'd0,
        REG_SW   = 2'd1,
        REG_DIGI = 2'd2,
        REG_CTRL = 2'd3
    } regSel_t;

    // Architectural state
    logic [7:0]        ledQ;
    logic [15:0]       digiQ;
    logic [1:0]        ctrlQ;
    logic [7:0]        swSync1;
    logic [7:0]        swSync2;
    logic [7:0]        swPrev;
    logic [DEB_W-1:0]  debCnt;
    logic [7:0]        swDeb;
    logic              swFlag;
    logic [SCAN_W-1:0] scanCnt;
    logic [1:0]        digitQ;
    logic [11:0]       digiOutQ;
    logic [31:0]       rDataQ;
    logic              readyQ;

    // Bus decode
    logic    inWin;
    regSel_t regSel;
    logic    wrEn;
    logic    rdEn;
    logic    swRdClr;

    assign inWin  = (iAddr[31:4] == 28'h400_0000);
    assign regSel = regSel_t'(iAddr[3:2]);
    assign wrEn   = iWE & inWin;
    // A simultaneous write suppresses the read.
    assign rdEn   = iRE & ~iWE & inWin;
    assign swRdClr = rdEn & (regSel == REG_SW);

    // Register next-state
    logic [7:0]  ledNext;
    logic [15:0] digiNext;
    logic [1:0]  ctrlNext;

    always_comb begin
        ledNext  = ledQ;
        digiNext = digiQ;
        ctrlNext = ctrlQ;
        if (wrEn) begin
            unique case (regSel)
                REG_LED:  ledNext  = iWData[7:0];
                REG_DIGI: digiNext = iWData[15:0];
                REG_CTRL: ctrlNext = iWData[1:0];
                default:  ;
            endcase
        end
    end

    // Read mux: SW returns the pre-clear flag value.
    logic [31:0] rdData;

    always_comb begin
        rdData = '0;
        if (rdEn) begin
            unique case (regSel)
                REG_LED:  rdData = {24'd0, ledQ};
                REG_SW:   rdData = {23'd0, swFlag, swDeb};
                REG_DIGI: rdData = {16'd0, digiQ};
                REG_CTRL: rdData = {30'd0, ctrlQ};
                default:  rdData = '0;
            endcase
        end
    end

    // Debounce: debCnt counts consecutive matching compares of the
    // synchronized sample. The compare that first sees a new value in
    // swSync2 is already that value's first stable cycle, so loading when
    // the count reaches DEB_CYCLES-2 gives DEB_CYCLES stable cycles.
    logic             swMatch;
    logic             debLoad;
    logic [DEB_W-1:0] debCntNext;
    logic [7:0]       swDebNext;
    logic             swFlagNext;

    always_comb begin
        swMatch    = (swSync2 == swPrev);
        debLoad    = swMatch && (debCnt == DEB_LOAD);
        debCntNext = debCnt;
        swDebNext  = swDeb;
        swFlagNext = swFlag;
        if (!swMatch) begin
            debCntNext = '0;
        end else if (debCnt != DEB_SAT) begin
            debCntNext = debCnt + 1'b1;
        end
        if (swRdClr) begin
            swFlagNext = 1'b0;
        end
        // A set on the same cycle as a clearing read wins.
        if (debLoad && (swPrev != swDeb)) begin
            swDebNext  = swPrev;
            swFlagNext = 1'b1;
        end
    end

    // Display scan. oDigi is built from next-state values so a register
    // write and a digit advance both show on the very next edge.
    logic [SCAN_W-1:0] scanNext;
    logic [1:0]        digitNext;
    logic [3:0]        nibble;
    logic [3:0]        anode;
    logic [7:0]        seg;
    logic [11:0]       digiOutNext;

    always_comb begin
        scanNext  = scanCnt + 1'b1;
        digitNext = digitQ;
        if (scanCnt == SCAN_LAST) begin
            scanNext  = '0;
            digitNext = digitQ + 1'b1;
        end

        unique case (digitNext)
            2'd0:    begin nibble = digiNext[3:0];   anode = 4'b1110; end
            2'd1:    begin nibble = digiNext[7:4];   anode = 4'b1101; end
            2'd2:    begin nibble = digiNext[11:8];  anode = 4'b1011; end
            default: begin nibble = digiNext[15:12]; anode = 4'b0111; end
        endcase

        unique case (nibble)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h90;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hC6;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase

        if (ctrlNext[1] && (digitNext == 2'd0)) begin
            seg[7] = 1'b0;
        end

        digiOutNext = ctrlNext[0] ? {anode, seg} : '1;
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            ledQ     <= '0;
            digiQ    <= '0;
            ctrlQ    <= '0;
            swSync1  <= '0;
            swSync2  <= '0;
            swPrev   <= '0;
            debCnt   <= '0;
            swDeb    <= '0;
            swFlag   <= 1'b0;
            scanCnt  <= '0;
            digitQ   <= '0;
            digiOutQ <= '1;
            rDataQ   <= '0;
            readyQ   <= 1'b0;
        end else begin
            ledQ     <= ledNext;
            digiQ    <= digiNext;
            ctrlQ    <= ctrlNext;
            swSync1  <= iSwitch;
            swSync2  <= swSync1;
            swPrev   <= swSync2;
            debCnt   <= debCntNext;
            swDeb    <= swDebNext;
            swFlag   <= swFlagNext;
            scanCnt  <= scanNext;
            digitQ   <= digitNext;
            digiOutQ <= digiOutNext;
            rDataQ   <= rdData;
            readyQ   <= iWE | iRE;
        end
    end

    assign oLED   = ledQ;
    assign oDigi  = digiOutQ;
    assign oRData = rDataQ;
    assign oReady = readyQ;

endmodule

// File: tb/tb_mmio_periph.sv
// Directed testbench for mmio_periph with small SCAN_DIV/DEB_CYCLES.
module tb_mmio_periph;

    localparam int unsigned SD = 4;
    localparam int unsigned DB = 8;

    localparam logic [31:0] A_LED  = 32'h4000_0000;
    localparam logic [31:0] A_SW   = 32'h4000_0004;
    localparam logic [31:0] A_DIGI = 32'h4000_0008;
    localparam logic [31:0] A_CTRL = 32'h4000_000C;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic        iWE;
    logic        iRE;
    logic [31:0] oRData;
    logic        oReady;
    logic [7:0]  iSwitch;
    logic [7:0]  oLED;
    logic [11:0] oDigi;

    int nCmp = 0;
    int nErr = 0;

    mmio_periph #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iAddr  (iAddr),
        .iWData (iWData),
        .iWE    (iWE),
        .iRE    (iRE),
        .oRData (oRData),
        .oReady (oReady),
        .iSwitch(iSwitch),
        .oLED   (oLED),
        .oDigi  (oDigi)
    );

    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d);
        iAddr  = a;
        iWData = d;
        iWE    = 1'b1;
        tick();
        iWE    = 1'b0;
        check({tag, "_rdy"}, {31'd0, oReady}, 32'd1);
    endtask

    task automatic rdChk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        iAddr = a;
        iRE   = 1'b1;
        tick();
        iRE   = 1'b0;
        check({tag, "_rdy"}, {31'd0, oReady}, 32'd1);
        check(tag, oRData, exp);
    endtask

    logic [11:0] scanExp [5] = '{12'hEC0, 12'hDF9, 12'hBA4, 12'h7B0, 12'hEC0};
    logic [11:0] prevDigi;
    logic        found;

    initial begin
        // Reset held with strobes active
        iRst_n  = 1'b0;
        iAddr   = A_LED;
        iWData  = 32'hFF;
        iWE     = 1'b1;
        iRE     = 1'b1;
        iSwitch = 8'h00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_ready", {31'd0, oReady}, 32'd0);
            check("rst_led", {24'd0, oLED}, 32'd0);
            check("rst_digi", {20'd0, oDigi}, 32'hFFF);
            check("rst_rdata", oRData, 32'd0);
        end
        iWE    = 1'b0;
        iRE    = 1'b0;
        iRst_n = 1'b1;
        tick();

        // LED access
        wr("wr_led", A_LED, 32'h0000_00A5);
        check("led_a5", {24'd0, oLED}, 32'hA5);
        rdChk("rd_led", A_LED, 32'h0000_00A5);
        tick();
        check("ready_drop", {31'd0, oReady}, 32'd0);
        check("rdata_drop", oRData, 32'd0);
        wr("wr_led2", A_LED, 32'hFFFF_FF5A);
        check("led_5a", {24'd0, oLED}, 32'h5A);
        rdChk("rd_led_upper0", A_LED, 32'h0000_005A);

        // Display
        wr("wr_digi", A_DIGI, 32'h0000_3210);
        check("disp_off", {20'd0, oDigi}, 32'hFFF);
        rdChk("rd_digi", A_DIGI, 32'h0000_3210);
        wr("wr_ctrl1", A_CTRL, 32'h1);
        found    = 1'b0;
        prevDigi = oDigi;
        for (int i = 0; i < 8 * SD && !found; i++) begin
            tick();
            if (prevDigi == 12'h7B0 && oDigi == 12'hEC0) found = 1'b1;
            prevDigi = oDigi;
        end
        check("scan_wrap_seen", {31'd0, found}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("scan_start%0d", k), {20'd0, oDigi}, {20'd0, scanExp[k]});
            repeat (SD - 1) tick();
            check($sformatf("scan_end%0d", k), {20'd0, oDigi}, {20'd0, scanExp[k]});
            tick();
        end

        wr("wr_ctrl3", A_CTRL, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 8 * SD && !found; i++) begin
            if (oDigi[11:8] == 4'hE) found = 1'b1;
            else tick();
        end
        check("dp_dig0_seen", {31'd0, found}, 32'd1);
        check("dp_dig0", {20'd0, oDigi}, 32'hE40);
        found = 1'b0;
        for (int i = 0; i < 8 * SD && !found; i++) begin
            if (oDigi[11:8] == 4'hD) found = 1'b1;
            else tick();
        end
        check("dp_dig1_seen", {31'd0, found}, 32'd1);
        check("dp_dig1_off", {20'd0, oDigi}, 32'hDF9);
        rdChk("rd_ctrl", A_CTRL, 32'h3);
        wr("wr_ctrl0", A_CTRL, 32'h0);
        check("disp_disable", {20'd0, oDigi}, 32'hFFF);

        // Debounce: bouncing input never settles
        for (int i = 0; i < 8; i++) begin
            iSwitch = (i % 2 == 0) ? 8'h0F : 8'h00;
            repeat (3) tick();
        end
        rdChk("sw_bounce", A_SW, 32'h000);
        repeat (DB + 4) tick();
        rdChk("sw_still0", A_SW, 32'h000);

        // Hold 0x0F: update lands 2+DB edges after the change
        iSwitch = 8'h0F;
        repeat (DB) tick();
        rdChk("sw_early", A_SW, 32'h000);
        tick();
        rdChk("sw_set", A_SW, 32'h10F);
        rdChk("sw_clr", A_SW, 32'h00F);

        // Flag race: read strobe on the update edge
        iSwitch = 8'h00;
        repeat (DB + 1) tick();
        rdChk("race_old", A_SW, 32'h00F);
        rdChk("race_kept", A_SW, 32'h100);
        rdChk("race_clr", A_SW, 32'h000);

        // Unmapped accesses
        rdChk("unmapped_rd", 32'h4000_0010, 32'h0);
        wr("unmapped_wr", 32'h4000_0010, 32'hFF);
        check("unmapped_led", {24'd0, oLED}, 32'h5A);
        wr("far_wr", 32'h5000_0000, 32'hFF);
        check("far_led", {24'd0, oLED}, 32'h5A);

        // Simultaneous write and read
        iAddr  = A_LED;
        iWData = 32'h3C;
        iWE    = 1'b1;
        iRE    = 1'b1;
        tick();
        iWE = 1'b0;
        iRE = 1'b0;
        check("both_rdy", {31'd0, oReady}, 32'd1);
        check("both_led", {24'd0, oLED}, 32'h3C);
        check("both_rdata", oRData, 32'd0);

        // Back-to-back reads
        iAddr = A_LED;
        iRE   = 1'b1;
        tick();
        check("b2b0_rdy", {31'd0, oReady}, 32'd1);
        check("b2b0", oRData, 32'h3C);
        iAddr = A_DIGI;
        tick();
        iRE = 1'b0;
        check("b2b1_rdy", {31'd0, oReady}, 32'd1);
        check("b2b1", oRData, 32'h3210);
        tick();
        check("b2b_idle", {31'd0, oReady}, 32'd0);

        // Reset during a transaction
        iAddr  = A_LED;
        iWData = 32'h77;
        iWE    = 1'b1;
        iRst_n = 1'b0;
        tick();
        iWE = 1'b0;
        check("midrst_rdy", {31'd0, oReady}, 32'd0);
        check("midrst_led", {24'd0, oLED}, 32'd0);
        check("midrst_digi", {20'd0, oDigi}, 32'hFFF);
        iRst_n = 1'b1;
        tick();
        rdChk("midrst_digi_reg", A_DIGI, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
